// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, 2-entry instruction buffer, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to the outputs when the buffer is empty.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_mem_req,
    output logic [31:0] inst_mem_address,
    input  logic        inst_mem_is_valid,
    input  logic [31:0] inst_mem_read_data,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_fetch_pc,
    output logic        exception
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  count_q, count_d;
    logic        exception_q, exception_d;
    logic [31:0] word0_q, word0_d, pc0_q, pc0_d;
    logic [31:0] word1_q, word1_d, pc1_q, pc1_d;

    logic        redirect_act, misaligned, bypass, pop, push;
    logic [1:0]  count_pop;

    // Once the exception is raised every later redirect is ignored until reset.
    always_comb begin
        redirect_act = redirect_valid && !exception_q;
        misaligned   = (redirect_pc[1:0] != 2'b00);
`ifdef FETCH_BYPASS_EN
        bypass = (state_q == WAIT) && (count_q == 2'd0) && inst_mem_is_valid && !redirect_act;
`else
        bypass = 1'b0;
`endif
        inst_valid = (count_q != 2'd0) || bypass;
        pop        = inst_valid && !stall && !redirect_act;
        push       = (state_q == WAIT) && inst_mem_is_valid && !redirect_act && !(bypass && !stall);
    end

    always_comb begin
        instruction   = NOP;
        inst_fetch_pc = fetch_pc_q;
        if (count_q != 2'd0) begin
            instruction   = word0_q;
            inst_fetch_pc = pc0_q;
        end
`ifdef FETCH_BYPASS_EN
        if (bypass) begin
            instruction   = inst_mem_read_data;
            inst_fetch_pc = addr_q;
        end
`endif
    end

    // NOTE: every signal gets its default first so no path through the block can infer a latch.
    always_comb begin
        word0_d   = word0_q;
        pc0_d     = pc0_q;
        word1_d   = word1_q;
        pc1_d     = pc1_q;
        count_pop = count_q;
        count_d   = count_q;
        if (redirect_act) begin
            count_d = 2'd0;
        end else begin
            if (pop && count_q != 2'd0) begin
                word0_d   = word1_q;
                pc0_d     = pc1_q;
                count_pop = count_q - 2'd1;
            end
            count_d = count_pop;
            if (push) begin
                if (count_pop == 2'd0) begin
                    word0_d = inst_mem_read_data;
                    pc0_d   = addr_q;
                end else begin
                    word1_d = inst_mem_read_data;
                    pc1_d   = addr_q;
                end
                count_d = count_pop + 2'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        exception_d = exception_q;
        if (redirect_act) begin
            fetch_pc_d = redirect_pc;
            if (misaligned) exception_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (redirect_act) begin
                    if (misaligned) state_d = HALT;
                end else if ((count_q < 2'd2) || pop) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            WAIT: begin
                if (redirect_act) begin
                    if (!inst_mem_is_valid) state_d = DRAIN;
                    else                    state_d = misaligned ? HALT : IDLE;
                end else if (inst_mem_is_valid) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = IDLE;
                end
            end
            // The response to the abandoned request is thrown away.
            DRAIN: begin
                if (inst_mem_is_valid) state_d = exception_d ? HALT : IDLE;
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            count_q     <= 2'd0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            exception_q <= exception_d;
        end
    end

    // NOTE: buffer storage needs no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        word0_q <= word0_d;
        pc0_q   <= pc0_d;
        word1_q <= word1_d;
        pc1_q   <= pc1_d;
    end

    assign inst_mem_req     = (state_q == WAIT) || (state_q == DRAIN);
    assign inst_mem_address = addr_q;
    assign exception        = exception_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Testbench for inst_fetch_ctrl: memory responder + expected-instruction scoreboard, directed and random phases.
module tb_inst_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_mem_req;
    logic [31:0] inst_mem_address;
    logic        inst_mem_is_valid = 1'b0;
    logic [31:0] inst_mem_read_data = '0;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_fetch_pc;
    logic        exception;

    inst_fetch_ctrl #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_mem_req(inst_mem_req), .inst_mem_address(inst_mem_address),
        .inst_mem_is_valid(inst_mem_is_valid), .inst_mem_read_data(inst_mem_read_data),
        .inst_valid(inst_valid), .instruction(instruction),
        .inst_fetch_pc(inst_fetch_pc), .exception(exception)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } item_t;

    int          checks = 0;
    int          errors = 0;
    item_t       exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] cons_log[$];
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] out_addr = '0;
    logic        out_active = 1'b0;
    logic        out_stale = 1'b0;
    logic        halted = 1'b0;
    int          out_wait = 0;
    int          lat = 1;
    int          lat_mode = 1;
    item_t       mon_it;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_at(input string name, input int sz, input int idx,
                            input logic [31:0] val, input logic [31:0] exp);
        if (idx < sz) check(name, val, exp);
        else          check({name, "_missing"}, 32'(sz), 32'(idx + 1));
    endtask

    function automatic int pick_lat();
        return (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
    endfunction

    // One cycle: drive inputs at the falling edge and act as the instruction memory.
    task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        stall = s;
        redirect_valid = rv;
        redirect_pc = rpc;
        inst_mem_is_valid = 1'b0;
        inst_mem_read_data = $urandom;
        if (inst_mem_req) begin
            if (!out_active) begin
                out_active = 1'b1;
                out_addr = inst_mem_address;
                out_wait = 0;
                out_stale = 1'b0;
                lat = pick_lat();
                req_log.push_back(inst_mem_address);
                if (halted) check("req_after_halt", {31'b0, inst_mem_req}, 32'd0);
                else        check("fetch_addr", inst_mem_address, exp_addr);
            end else begin
                check("addr_stable", inst_mem_address, out_addr);
            end
            if (out_wait >= lat) begin
                inst_mem_is_valid = 1'b1;
                inst_mem_read_data = mem_word(out_addr);
                out_active = 1'b0;
                if (!rv && !out_stale && !halted) begin
                    exp_q.push_back({out_addr, mem_word(out_addr)});
                    exp_addr = out_addr + 32'd4;
                end
            end else begin
                out_wait++;
            end
        end else if (out_active) begin
            check("req_dropped_early", {31'b0, inst_mem_req}, 32'd1);
            out_active = 1'b0;
        end
        if (rv && !halted) begin
            exp_q.delete();
            if (out_active) out_stale = 1'b1;
            if (rpc[1:0] != 2'b00) halted = 1'b1;
            else                   exp_addr = rpc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        inst_mem_is_valid = 1'b0;
        @(negedge clk);
        check("rst_req", {31'b0, inst_mem_req}, 32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_instr", instruction, NOP);
        check("rst_pc", inst_fetch_pc, RESET_PC);
        check("rst_exc", {31'b0, exception}, 32'd0);
        reset = 1'b0;
        inst_mem_is_valid = 1'b1;
        inst_mem_read_data = 32'hDEAD_BEEF;
        exp_q.delete();
        req_log.delete();
        cons_log.delete();
        exp_addr = RESET_PC;
        out_active = 1'b0;
        halted = 1'b0;
        check("req_first_cycle", {31'b0, inst_mem_req}, 32'd0);
        @(negedge clk);
        inst_mem_is_valid = 1'b0;
        inst_mem_read_data = $urandom;
        check("req_second_cycle", {31'b0, inst_mem_req}, 32'd1);
        check("first_addr", inst_mem_address, RESET_PC);
        out_active = 1'b1;
        out_addr = inst_mem_address;
        out_wait = 1;
        out_stale = 1'b0;
        lat = pick_lat();
        req_log.push_back(inst_mem_address);
        exp_addr = RESET_PC;
    endtask

    // Monitor: every consumed instruction must be the oldest accepted response.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (!halted) check("exception_low", {31'b0, exception}, 32'd0);
            if (inst_valid) begin
                if (!stall && !redirect_valid) begin
                    cons_log.push_back(inst_fetch_pc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_inst", {31'b0, inst_valid}, 32'd0);
                    end else begin
                        mon_it = exp_q.pop_front();
                        check("out_pc", inst_fetch_pc, mon_it.pc);
                        check("out_instr", instruction, mon_it.word);
                    end
                end
            end else begin
                check("nop_when_empty", instruction, NOP);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // Sequential fetch with one-cycle memory latency and base output latency.
        lat_mode = 1;
        do_reset();
        step(1'b0, 1'b0, '0);
        #1;
`ifdef FETCH_BYPASS_EN
        check("bypass_same_cycle_valid", {31'b0, inst_valid}, 32'd1);
        check("bypass_same_cycle_instr", instruction, mem_word(RESET_PC));
`else
        check("lat_no_same_cycle", {31'b0, inst_valid}, 32'd0);
        step(1'b0, 1'b0, '0);
        #1;
        check("lat_next_cycle_valid", {31'b0, inst_valid}, 32'd1);
        check("lat_next_cycle_pc", inst_fetch_pc, RESET_PC);
`endif
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check_at("seq_req0", req_log.size(), 0, req_log[0], 32'h0);
        check_at("seq_req1", req_log.size(), 1, req_log[1], 32'h4);
        check_at("seq_req2", req_log.size(), 2, req_log[2], 32'h8);
        check_at("seq_out2", cons_log.size(), 2, cons_log[2], 32'h8);

        // Long stall: buffer fills with two entries and fetching stops.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        #1;
        check("full_req_low", {31'b0, inst_mem_req}, 32'd0);
        check("full_valid", {31'b0, inst_valid}, 32'd1);
        check("full_head_pc", inst_fetch_pc, 32'h0);
        check("full_req_count", 32'(req_log.size()), 32'd2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check_at("release_out0", cons_log.size(), 0, cons_log[0], 32'h0);
        check_at("release_out1", cons_log.size(), 1, cons_log[1], 32'h4);
        check_at("release_out2", cons_log.size(), 2, cons_log[2], 32'h8);

        // Redirect while waiting on 0x8: old response drained and discarded.
        lat_mode = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, '0);
            if (out_active && out_addr == 32'h8) found = 1'b1;
        end
        check("drain_setup_found", {31'b0, found}, 32'd1);
        step(1'b0, 1'b1, 32'h100);
        req_log.delete();
        cons_log.delete();
        step(1'b0, 1'b0, '0);
        #1;
        check("drain_req_held", {31'b0, inst_mem_req}, 32'd1);
        check("drain_addr_held", inst_mem_address, 32'h8);
        check("drain_no_valid", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0);
        check_at("drain_next_req", req_log.size(), 0, req_log[0], 32'h100);
        check_at("drain_first_out", cons_log.size(), 0, cons_log[0], 32'h100);

        // Redirect in the same cycle as the response: the response is dropped.
        lat_mode = 1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, '0);
            if (out_active && out_addr == 32'h4) found = 1'b1;
        end
        check("coincide_setup_found", {31'b0, found}, 32'd1);
        step(1'b0, 1'b1, 32'h200);
        req_log.delete();
        cons_log.delete();
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0);
        check_at("coincide_next_req", req_log.size(), 0, req_log[0], 32'h200);
        check_at("coincide_first_out", cons_log.size(), 0, cons_log[0], 32'h200);

        // Misaligned redirect: exception, empty buffer, no further requests.
        step(1'b0, 1'b1, 32'h102);
        req_log.delete();
        step(1'b0, 1'b0, '0);
        #1;
        check("misalign_exc", {31'b0, exception}, 32'd1);
        check("misalign_flush", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 20; i++) step(1'(($urandom & 1)), 1'b1, 32'h300);
        #1;
        check("halt_req_low", {31'b0, inst_mem_req}, 32'd0);
        check("halt_exc_sticky", {31'b0, exception}, 32'd1);
        check("halt_no_new_req", 32'(req_log.size()), 32'd0);

        // Reset during an outstanding request drops it and restarts at RESET_PC.
        do_reset();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check_at("restart_out0", cons_log.size(), 0, cons_log[0], RESET_PC);

        // Random stalls, latencies and aligned redirects (including near the wrap point).
        lat_mode = -1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0), rpc);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check("residual_bounded", {31'b0, exp_q.size() <= 2}, 32'd1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
